// File: rtl/reg_dump_scanner.sv
// Streams registers RegFirst..RegLast from the register file debug port over valid/ready,
// tagging each word as changed relative to the shadow copy of the last completed dump.
module reg_dump_scanner #(
   parameter int unsigned RegFirst = 0,
   parameter int unsigned RegLast  = 31
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        abort_i,
   output logic [4:0]  dbg_reg_o,
   input  logic [31:0] dbg_content_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic [4:0]  out_index_o,
   output logic        out_changed_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [4:0] FirstIdx = 5'(RegFirst);
   localparam logic [4:0] LastIdx  = 5'(RegLast);

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StSend,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  index_q, index_d;
   logic        changed_q, changed_d;
   logic        shadow_valid_q, shadow_valid_d;
   logic [31:0] shadow_q [32];
   logic        shadow_we;
   logic        handshake;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      data_d         = data_q;
      index_d        = index_q;
      changed_d      = changed_q;
      shadow_valid_d = shadow_valid_q;
      shadow_we      = 1'b0;
      handshake      = (state_q == StSend) && out_ready_i;

      unique case (state_q)
         StIdle: begin
            if (start_i && !abort_i) begin
               idx_d   = FirstIdx;
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (abort_i) begin
               state_d = StIdle;
            end else begin
               data_d    = dbg_content_i;
               index_d   = idx_q;
               changed_d = !shadow_valid_q || (shadow_q[idx_q] != dbg_content_i);
               state_d   = StSend;
            end
         end
         StSend: begin
            // An accepted word updates the shadow even if abort arrives in the same cycle.
            shadow_we = handshake;
            if (abort_i) begin
               state_d = StIdle;
            end else if (handshake) begin
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = StFetch;
               end
            end
         end
         StDone: begin
            shadow_valid_d = 1'b1;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= StIdle;
         idx_q          <= FirstIdx;
         data_q         <= '0;
         index_q        <= '0;
         changed_q      <= 1'b0;
         shadow_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         data_q         <= data_d;
         index_q        <= index_d;
         changed_q      <= changed_d;
         shadow_valid_q <= shadow_valid_d;
      end
   end

   // Shadow contents are meaningless until shadow_valid_q is set, so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (shadow_we && !rst_i) begin
         shadow_q[index_q] <= data_q;
      end
   end

   assign dbg_reg_o     = idx_q;
   assign out_valid_o   = (state_q == StSend);
   assign out_data_o    = data_q;
   assign out_index_o   = index_q;
   assign out_changed_o = changed_q;
   assign busy_o        = (state_q != StIdle);
   assign done_o        = (state_q == StDone);

endmodule
